// File: rtl/pipe_barrel_shifter.sv
// Pipelined logarithmic barrel shifter: one registered stage per shift-count bit,
// largest step first, with a single global advance enable for backpressure.
module pipe_barrel_shifter #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_count,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [2:0] {
        MODE_LSL = 3'b000,
        MODE_LSR = 3'b001,
        MODE_ASR = 3'b010,
        MODE_ROL = 3'b011,
        MODE_ROR = 3'b100
    } mode_e;

    // One fixed-size step; reserved modes pass the operand through untouched.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic [2:0]       mode,
                                                    input int               amt);
        logic [WIDTH-1:0] r;
        case (mode)
            MODE_LSL: r = d << amt;
            MODE_LSR: r = d >> amt;
            MODE_ASR: r = $signed(d) >>> amt;
            MODE_ROL: r = (d << amt) | (d >> (WIDTH - amt));
            MODE_ROR: r = (d >> amt) | (d << (WIDTH - amt));
            default:  r = d;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] st_data  [SHW];
    logic [SHW-1:0]   st_count [SHW];
    logic [2:0]       st_mode  [SHW];
    logic [SHW-1:0]   st_valid;

    logic [WIDTH-1:0] src_data  [SHW];
    logic [SHW-1:0]   src_count [SHW];
    logic [2:0]       src_mode  [SHW];
    logic [SHW-1:0]   src_valid;
    logic [WIDTH-1:0] stp_data  [SHW];

    logic adv;

    assign adv       = !st_valid[SHW-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = st_valid[SHW-1];
    assign out_data  = st_data[SHW-1];

    always_comb begin
        src_data[0]  = in_data;
        src_count[0] = in_count;
        src_mode[0]  = in_mode;
        src_valid[0] = in_valid;
        for (int k = 1; k < SHW; k++) begin
            src_data[k]  = st_data[k-1];
            src_count[k] = st_count[k-1];
            src_mode[k]  = st_mode[k-1];
            src_valid[k] = st_valid[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            if (src_count[k][SHW-1-k])
                stp_data[k] = shift_step(src_data[k], src_mode[k], 1 << (SHW - 1 - k));
            else
                stp_data[k] = src_data[k];
        end
    end

    // NOTE: only the valid bits and the output data are reset; the inner stage
    // data is qualified by its valid bit, so it simply holds during reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_valid       <= '0;
            st_data[SHW-1] <= '0;
        end else if (adv) begin
            for (int k = 0; k < SHW; k++) begin
                st_data[k]  <= stp_data[k];
                st_count[k] <= src_count[k];
                st_mode[k]  <= src_mode[k];
                st_valid[k] <= src_valid[k];
            end
        end
    end

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Directed-vector and scoreboard bench for pipe_barrel_shifter at WIDTH=8.
module tb_pipe_barrel_shifter;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_count;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    int checks = 0;
    int errors = 0;

    pipe_barrel_shifter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_count (in_count),
        .in_mode  (in_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       mode;
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   count;
        logic [WIDTH-1:0] expected;
    } vec_t;

    vec_t vecs [12];
    logic [WIDTH-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bit-by-bit reference: each result bit names the source bit it comes from.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d,
                                                   input int c, input logic [2:0] m);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            case (m)
                3'b000:  r[i] = (i >= c) ? d[i-c] : 1'b0;
                3'b001:  r[i] = (i + c < WIDTH) ? d[i+c] : 1'b0;
                3'b010:  r[i] = (i + c < WIDTH) ? d[i+c] : d[WIDTH-1];
                3'b011:  r[i] = d[(i - c + WIDTH) % WIDTH];
                3'b100:  r[i] = d[(i + c) % WIDTH];
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One scoreboarded cycle: inputs already driven; returns whether a transfer happened.
    task automatic cycle(input string tag, output bit xfer);
        bit cons, hold;
        logic [WIDTH-1:0] prev;
        #1;
        xfer = in_valid && in_ready;
        cons = out_valid && out_ready;
        hold = out_valid && !out_ready;
        prev = out_data;
        if (out_valid) check({tag, "_in_ready_vs_out_ready"}, in_ready, out_ready);
        if (cons) begin
            if (exp_q.size() == 0) begin
                check({tag, "_unexpected_result"}, 1, 0);
            end else begin
                check({tag, "_result"}, out_data, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
        if (xfer) exp_q.push_back(ref_shift(in_data, int'(in_count), in_mode));
        @(posedge clk);
        #1;
        if (hold) begin
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_data"}, out_data, prev);
        end
    endtask

    task automatic drain(input string tag);
        bit x;
        int budget = 30;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && budget > 0) begin
            cycle(tag, x);
            budget--;
        end
        check({tag, "_drained_remaining"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        bit x;
        int idx;
        logic [WIDTH-1:0] bp_data [4];

        vecs[0]  = '{3'b000, 8'h81, 3'd3, 8'h08};
        vecs[1]  = '{3'b010, 8'h90, 3'd2, 8'hE4};
        vecs[2]  = '{3'b001, 8'hFF, 3'd7, 8'h01};
        vecs[3]  = '{3'b011, 8'h81, 3'd7, 8'hC0};
        vecs[4]  = '{3'b100, 8'h81, 3'd1, 8'hC0};
        vecs[5]  = '{3'b110, 8'h5A, 3'd5, 8'h5A};
        vecs[6]  = '{3'b011, 8'h81, 3'd0, 8'h81};
        vecs[7]  = '{3'b010, 8'h7F, 3'd3, 8'h0F};
        vecs[8]  = '{3'b111, 8'hA5, 3'd7, 8'hA5};
        vecs[9]  = '{3'b000, 8'hFF, 3'd7, 8'h80};
        vecs[10] = '{3'b100, 8'h12, 3'd4, 8'h21};
        vecs[11] = '{3'b010, 8'h80, 3'd7, 8'hFF};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_count = '0;
        in_mode = '0; out_ready = 1'b1;
        step();
        step();
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        step();

        // Single operations: result visible after the transfer edge plus SHW-1 more.
        for (int v = 0; v < 12; v++) begin
            in_valid = 1'b1; in_data = vecs[v].data;
            in_count = vecs[v].count; in_mode = vecs[v].mode;
            #1;
            check($sformatf("vec%0d_in_ready", v), in_ready, 1);
            step();
            in_valid = 1'b0;
            for (int c = 1; c < SHW; c++) begin
                check($sformatf("vec%0d_early_valid_c%0d", v, c), out_valid, 0);
                step();
            end
            check($sformatf("vec%0d_valid", v), out_valid, 1);
            check($sformatf("vec%0d_data", v), out_data, vecs[v].expected);
            step();
            check($sformatf("vec%0d_empty_after", v), out_valid, 0);
        end

        // Back-to-back: LSL 0x01 by 0..7 on consecutive edges.
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 8); in_data = 8'h01;
            in_count = SHW'(c); in_mode = 3'b000;
            step();
            if (c >= SHW - 1) begin
                check($sformatf("b2b_valid_c%0d", c), out_valid, 1);
                check($sformatf("b2b_data_c%0d", c), out_data, 8'h01 << (c - (SHW - 1)));
            end
        end
        in_valid = 1'b0;
        step();
        check("b2b_empty_after", out_valid, 0);

        // Backpressure: 5 stalled cycles while 4 operations stream in.
        bp_data = '{8'h01, 8'h03, 8'h07, 8'h0F};
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            out_ready = 1'b0;
            in_valid = (idx < 4); in_data = bp_data[idx % 4];
            in_count = SHW'(idx + 1); in_mode = 3'b100;
            cycle("bp_stall", x);
            if (x) idx++;
        end
        check("bp_stall_out_valid", out_valid, 1);
        check("bp_stall_in_ready", in_ready, 0);
        check("bp_stall_first_data", out_data, 8'h80);
        for (int c = 0; c < 20 && idx < 4; c++) begin
            out_ready = 1'b1;
            in_valid = 1'b1; in_data = bp_data[idx];
            in_count = SHW'(idx + 1); in_mode = 3'b100;
            cycle("bp_release", x);
            if (x) idx++;
        end
        check("bp_all_accepted", idx, 4);
        drain("bp_drain");

        // Reset with three operations in flight; a new op offered during reset is ignored.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_data = 8'h3C + 8'(c); in_count = 3'd1; in_mode = 3'b000;
            step();
        end
        check("rst_pre_valid", out_valid, 1);
        rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
        step();
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_out_data", out_data, 0);
        check("rst_mid_in_ready", in_ready, 1);
        rst_n = 1'b1; in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            out_ready = c[0];
            step();
            check($sformatf("rst_no_stale_c%0d", c), out_valid, 0);
        end

        // Random streaming against the reference model.
        idx = 0;
        for (int c = 0; c < 40000 && idx < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = WIDTH'($urandom);
            in_count  = SHW'($urandom);
            in_mode   = 3'($urandom_range(0, 7));
            cycle("rand", x);
            if (x) idx++;
        end
        check("rand_transfers", idx, 10000);
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
